// File: rtl/fifo_write_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and default sizing for the FIFO write arbiter
// Revision     : 1.0
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_DATA_W    = 8;
    localparam int ARB_MAX_BURST = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_write_arbiter_if : producer request bus plus FIFO write-port pins
// Revision              : 1.0
// ----------------------------------------------------------------------------
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int DATA_W  = ARB_DATA_W
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         gnt;
    logic                       fifo_full;
    logic                       fifo_write_enable;
    logic [DATA_W-1:0]          fifo_data_in;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] owner;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_write_enable, fifo_data_in, busy, owner
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_write_enable, fifo_data_in, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_picker : combinational round-robin pick of the first request at/after rr_ptr
// Revision  : 1.0
// ----------------------------------------------------------------------------
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       pick_valid,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap the scan position back into 0..NUM_REQ-1
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                w_idx = IDX_W'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                w_idx = IDX_W'(int'(rr_ptr) + k);
            end
            if (!pick_valid && req[w_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_write_arbiter : round-robin burst arbiter for the shared FIFO write port
// Revision           : 1.0
// ----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = ARB_NUM_REQ,
    parameter int DATA_W    = ARB_DATA_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                 clock,
    input  logic                 reset_n,
    fifo_write_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] c_max_beats = CNT_W'(MAX_BURST);

    arb_state_t       r_state,    w_next_state;
    logic [IDX_W-1:0] r_owner,    w_next_owner;
    logic [IDX_W-1:0] r_rr_ptr,   w_next_rr;
    logic [CNT_W-1:0] r_beat_cnt, w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [IDX_W-1:0] w_owner_inc;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic [DATA_W-1:0] w_slice [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign w_slice[i] = bus.req_data[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_picker (
        .req        (bus.req),
        .rr_ptr     (r_rr_ptr),
        .pick_valid (w_pick_valid),
        .pick_idx   (w_pick_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_owner    <= w_next_owner;
            r_rr_ptr   <= w_next_rr;
            r_beat_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state          = r_state;
        w_next_owner          = r_owner;
        w_next_rr             = r_rr_ptr;
        w_next_cnt            = r_beat_cnt;
        w_cnt_inc             = r_beat_cnt + 1'b1;
        w_owner_inc           = (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
        bus.gnt               = '0;
        bus.fifo_write_enable = 1'b0;
        bus.fifo_data_in      = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = BURST;
                    w_next_owner = w_pick_idx;
                    w_next_cnt   = '0;
                end
            end
            BURST: begin
                bus.fifo_data_in = w_slice[r_owner];
                if (!bus.req[r_owner]) begin
                    w_next_state = IDLE;
                    w_next_rr    = w_owner_inc;
                end else if (!bus.fifo_full) begin
                    // Stall cycles fall through here untouched, so they never count
                    bus.gnt[r_owner]      = 1'b1;
                    bus.fifo_write_enable = 1'b1;
                    w_next_cnt            = w_cnt_inc;
                    if (bus.req_last[r_owner] || (w_cnt_inc == c_max_beats)) begin
                        w_next_state = IDLE;
                        w_next_rr    = w_owner_inc;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.busy  = (r_state == BURST);
    assign bus.owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_write_arbiter : directed self-checking bench for fifo_write_arbiter
// Revision              : 1.0
// ----------------------------------------------------------------------------
module tb_fifo_write_arbiter;
    logic clock;
    logic reset_n;
    int   n_tests;
    int   n_fail;
    int   n_wr;
    int   exp_owner [6];

    fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // New inputs apply to the cycle after the next rising edge; sampled 2 time units in
    task automatic drive(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l,
                         input logic f, input logic rn);
        @(posedge clock);
        #1;
        reset_n      = rn;
        bus.req      = r;
        bus.req_data = d;
        bus.req_last = l;
        bus.fifo_full = f;
        #1;
        chk("no_write_when_full", 32'(bus.fifo_write_enable & bus.fifo_full), 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_wr    = 0;
        exp_owner = '{0, 1, 2, 3, 0, 1};
        reset_n = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("rst_gnt",   32'(bus.gnt), 32'h0);
        chk("rst_we",    32'(bus.fifo_write_enable), 32'h0);
        chk("rst_data",  32'(bus.fifo_data_in), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);

        // Single producer, 3-beat burst on slot 2
        drive(4'b0100, 32'h00A1_0000, 4'h0, 1'b0, 1'b1);
        chk("single_lat_gnt", 32'(bus.gnt), 32'h0);
        drive(4'b0100, 32'h00A1_0000, 4'h0, 1'b0, 1'b1);
        chk("single_b1_gnt",  32'(bus.gnt), 32'h4);
        chk("single_b1_data", 32'(bus.fifo_data_in), 32'hA1);
        chk("single_b1_we",   32'(bus.fifo_write_enable), 32'h1);
        chk("single_owner",   32'(bus.owner), 32'h2);
        drive(4'b0100, 32'h00A2_0000, 4'h0, 1'b0, 1'b1);
        chk("single_b2_gnt",  32'(bus.gnt), 32'h4);
        chk("single_b2_data", 32'(bus.fifo_data_in), 32'hA2);
        drive(4'b0100, 32'h00A3_0000, 4'b0100, 1'b0, 1'b1);
        chk("single_b3_gnt",  32'(bus.gnt), 32'h4);
        chk("single_b3_data", 32'(bus.fifo_data_in), 32'hA3);
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("single_end_busy",  32'(bus.busy), 32'h0);
        chk("single_end_data",  32'(bus.fifo_data_in), 32'h0);
        chk("single_end_owner", 32'(bus.owner), 32'h2);

        // Fairness: rotation resumes at 3, then 0,1,2,3,0,1
        drive(4'hF, 32'h1312_1110, 4'hF, 1'b0, 1'b1);
        chk("fair_idle0_busy", 32'(bus.busy), 32'h0);
        drive(4'hF, 32'h1312_1110, 4'hF, 1'b0, 1'b1);
        chk("fair_first_gnt", 32'(bus.gnt), 32'h8);
        for (int i = 0; i < 6; i++) begin
            drive(4'hF, 32'h1312_1110, 4'hF, 1'b0, 1'b1);
            chk("fair_gap_gnt", 32'(bus.gnt), 32'h0);
            drive(4'hF, 32'h1312_1110, 4'hF, 1'b0, 1'b1);
            chk("fair_owner", 32'(bus.owner), 32'(exp_owner[i]));
            chk("fair_gnt",   32'(bus.gnt), 32'h1 << exp_owner[i]);
            chk("fair_data",  32'(bus.fifo_data_in), 32'h10 + 32'(exp_owner[i]));
        end
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        chk("fair_end_busy", 32'(bus.busy), 32'h0);

        // Burst cap: slot 1 never raises last
        drive(4'b0010, 32'h0000_B000, 4'h0, 1'b0, 1'b1);
        chk("cap_lat_gnt", 32'(bus.gnt), 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0010, 32'(8'hB0 + k) << 8, 4'h0, 1'b0, 1'b1);
            chk("cap_gnt",  32'(bus.gnt), 32'h2);
            chk("cap_data", 32'(bus.fifo_data_in), 32'hB0 + 32'(k));
        end
        drive(4'b0010, 32'h0000_C000, 4'h0, 1'b0, 1'b1);
        chk("cap_gap_busy", 32'(bus.busy), 32'h0);
        chk("cap_gap_gnt",  32'(bus.gnt), 32'h0);

        // Re-grant to lone requester, with a 5-cycle full stall after beat 1
        drive(4'b0010, 32'h0000_C000, 4'h0, 1'b0, 1'b1);
        chk("regrant_gnt", 32'(bus.gnt), 32'h2);
        n_wr += int'(bus.fifo_write_enable);
        for (int k = 0; k < 5; k++) begin
            drive(4'b0010, 32'h0000_C100, 4'h0, 1'b1, 1'b1);
            chk("stall_gnt",  32'(bus.gnt), 32'h0);
            chk("stall_busy", 32'(bus.busy), 32'h1);
            n_wr += int'(bus.fifo_write_enable);
        end
        for (int k = 1; k < 4; k++) begin
            drive(4'b0010, 32'(8'hC0 + k) << 8, 4'h0, 1'b0, 1'b1);
            chk("resume_gnt",  32'(bus.gnt), 32'h2);
            chk("resume_data", 32'(bus.fifo_data_in), 32'hC0 + 32'(k));
            n_wr += int'(bus.fifo_write_enable);
        end
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        n_wr += int'(bus.fifo_write_enable);
        chk("stall_end_busy", 32'(bus.busy), 32'h0);
        chk("stall_total_wr", 32'(n_wr), 32'h4);

        // Abandon: owner 0 drops req after 2 beats while 3 waits
        drive(4'b0001, 32'h0000_00C1, 4'h0, 1'b0, 1'b1);
        drive(4'b0001, 32'h0000_00C1, 4'h0, 1'b0, 1'b1);
        chk("abn_b1_gnt", 32'(bus.gnt), 32'h1);
        drive(4'b1001, 32'hDD00_00C2, 4'h0, 1'b0, 1'b1);
        chk("abn_b2_gnt", 32'(bus.gnt), 32'h1);
        drive(4'b1000, 32'hDD00_00C3, 4'h0, 1'b0, 1'b1);
        chk("abn_drop_we",   32'(bus.fifo_write_enable), 32'h0);
        chk("abn_drop_gnt",  32'(bus.gnt), 32'h0);
        drive(4'b1000, 32'hD100_0000, 4'h0, 1'b0, 1'b1);
        chk("abn_idle_busy", 32'(bus.busy), 32'h0);
        drive(4'b1000, 32'hD100_0000, 4'h0, 1'b0, 1'b1);
        chk("abn_next_owner", 32'(bus.owner), 32'h3);
        chk("abn_next_gnt",   32'(bus.gnt), 32'h8);

        // Reset during beat 2 of owner 3's burst
        drive(4'b1000, 32'hD200_0000, 4'h0, 1'b0, 1'b0);
        chk("rstmid_b2_gnt", 32'(bus.gnt), 32'h8);
        drive(4'b1001, 32'hD300_00E0, 4'h0, 1'b0, 1'b1);
        chk("rstmid_busy",  32'(bus.busy), 32'h0);
        chk("rstmid_owner", 32'(bus.owner), 32'h0);
        chk("rstmid_we",    32'(bus.fifo_write_enable), 32'h0);
        drive(4'b1001, 32'hD300_00E0, 4'h0, 1'b0, 1'b1);
        chk("rstmid_scan_owner", 32'(bus.owner), 32'h0);
        chk("rstmid_scan_gnt",   32'(bus.gnt), 32'h1);
        drive(4'h0, 32'h0, 4'h0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
